inst_loader: RTL

Boot-time instruction store sitting directly upstream of the single-cycle CPU: it receives a program as a byte stream, assembles 32-bit instructions into an internal instruction memory, verifies a checksum, and then releases the CPU from reset. After release it serves the CPU's instruction bus combinationally, returning the instruction at the requested address in the same cycle, as a single-cycle fetch requires.

---
 rtl/inst_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction store: assembles a checksummed byte stream into instruction memory,
// then releases the CPU from reset and serves single-cycle combinational fetches.
`timescale 1ns/1ps
module inst_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [63:0] IAB,
  output logic [31:0] IDB,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [31:0] Nop = 32'hD503201F;

  typedef enum logic [2:0] {StHdr0, StHdr1, StData, StCsum, StRun, StErr} state_e;

  state_e        state_q, state_d;
  logic [7:0]    hdr_lo_q, hdr_lo_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   valid_q, valid_d;
  logic [AW-1:0] word_idx_q, word_idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   asm_q, asm_d;
  logic [7:0]    xor_q, xor_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [15:0]   n_full;
  logic [AW:0]   words_done;
  logic [AW-1:0] fetch_idx;
  logic          fetch_hit;
  logic          unused_iab;

  logic [31:0]   mem [DEPTH];

  assign rx_ready   = (state_q != StRun) && (state_q != StErr);
  assign accept     = rx_valid && rx_ready;
  assign n_full     = {rx_data, hdr_lo_q};
  assign words_done = {1'b0, word_idx_q} + (AW+1)'(1);
  assign mem_wdata  = {rx_data, asm_q};

  always_comb begin
    state_d     = state_q;
    hdr_lo_d    = hdr_lo_q;
    count_d     = count_q;
    valid_d     = valid_q;
    word_idx_d  = word_idx_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    xor_d       = xor_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    unique case (state_q)
      StHdr0: begin
        if (accept) begin
          hdr_lo_d = rx_data;
          state_d  = StHdr1;
        end
      end
      StHdr1: begin
        if (accept) begin
          if ((n_full == 16'd0) || (n_full > 16'(DEPTH))) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            count_d    = n_full[AW:0];
            lane_d     = 2'd0;
            word_idx_d = '0;
            xor_d      = 8'h00;
            state_d    = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          xor_d  = xor_q ^ rx_data;
          // Little-endian: newest byte enters at the top, so byte 0 ends up in [7:0].
          asm_d  = {rx_data, asm_q[23:8]};
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            mem_we     = 1'b1;
            word_idx_d = word_idx_q + 1'b1;
            if (words_done == count_q) state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          if (rx_data == xor_q) begin
            state_d     = StRun;
            valid_d     = count_q;
            cpu_rst_n_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      StRun, StErr: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHdr0;
      hdr_lo_q    <= 8'h00;
      count_q     <= '0;
      valid_q     <= '0;
      word_idx_q  <= '0;
      lane_q      <= 2'd0;
      asm_q       <= 24'h0;
      xor_q       <= 8'h00;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_lo_q    <= hdr_lo_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      word_idx_q  <= word_idx_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      xor_q       <= xor_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Memory survives reset; only the valid count guards stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx_q] <= mem_wdata;
  end

  assign cpu_rst_n = cpu_rst_n_q;
  assign load_done = done_q;
  assign load_err  = err_q;

  assign fetch_idx  = IAB[AW+1:2];
  assign fetch_hit  = (state_q == StRun) && (IAB[63:AW+2] == '0) &&
                      ({1'b0, fetch_idx} < valid_q);
  assign IDB        = fetch_hit ? mem[fetch_idx] : Nop;
  assign unused_iab = ^IAB[1:0];

endmodule
